sfu_sequencer: RTL and testbench

//  Multi-cycle special function unit (SFU) that replaces the combinational FS decoder.

---
 rtl/sfu_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_sfu_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/sfu_sequencer.sv
// Multi-cycle special function unit: MUL (shift-add), ADC, ASR (bit-serial), CLR/SET/TST.
// Start/Busy/Done handshake; results and flags are held until the next Done.
module sfu_sequencer #(
    parameter int WIDTH   = 16,
    parameter int SHIFT_W = $clog2(WIDTH)
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Start,
    input  logic [4:0]       FS,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             SFU_sel,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] ResultHi,
    output logic             C,
    output logic             Z,
    output logic             N
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [4:0] FS_MUL = 5'b11010;
    localparam logic [4:0] FS_ADC = 5'b11011;
    localparam logic [4:0] FS_ASR = 5'b11100;
    localparam logic [4:0] FS_CLR = 5'b11101;
    localparam logic [4:0] FS_SET = 5'b11110;
    localparam logic [4:0] FS_TST = 5'b11111;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_SHIFT, S_DONE} state_t;

    state_t                 state_reg, state_next;
    logic [2*WIDTH-1:0]     prod_reg, prod_next;
    logic [WIDTH-1:0]       mcand_reg, mcand_next;
    logic [WIDTH-1:0]       sh_reg, sh_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [WIDTH-1:0]       res_lo_reg, res_lo_next;
    logic [WIDTH-1:0]       res_hi_reg, res_hi_next;
    logic                   c_reg, c_next, z_reg, z_next, n_reg, n_next;

    logic [SHIFT_W-1:0]     idx;
    logic [WIDTH-1:0]       bitmask;
    logic [WIDTH:0]         adc_sum;
    logic [WIDTH:0]         mul_sum;
    logic [WIDTH-1:0]       shifted;
    logic                   accept;

    // Result write-back bundle, applied once when an op finishes
    logic                   wr, wr_c, wr_z, is_tst;
    logic [WIDTH-1:0]       wr_lo, wr_hi;

    assign SFU_sel = (FS >= FS_MUL);
    assign accept  = Start && SFU_sel && (state_reg == S_IDLE || state_reg == S_DONE);
    assign idx     = B[SHIFT_W-1:0];
    assign bitmask = {{(WIDTH-1){1'b0}}, 1'b1} << idx;
    assign adc_sum = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
    // One shift-add step: conditionally add multiplicand into the high half, then shift right
    assign mul_sum = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} + (prod_reg[0] ? {1'b0, mcand_reg} : '0);
    assign shifted = {sh_reg[WIDTH-1], sh_reg[WIDTH-1:1]};

    always_comb begin
        state_next  = state_reg;
        prod_next   = prod_reg;
        mcand_next  = mcand_reg;
        sh_next     = sh_reg;
        cnt_next    = cnt_reg;
        res_lo_next = res_lo_reg;
        res_hi_next = res_hi_reg;
        c_next      = c_reg;
        z_next      = z_reg;
        n_next      = n_reg;
        wr          = 1'b0;
        wr_lo       = '0;
        wr_hi       = '0;
        wr_c        = 1'b0;
        wr_z        = 1'b0;
        is_tst      = 1'b0;

        case (state_reg)
            S_MUL: begin
                if (cnt_reg == CNT_W'(WIDTH)) begin
                    wr         = 1'b1;
                    wr_lo      = prod_reg[WIDTH-1:0];
                    wr_hi      = prod_reg[2*WIDTH-1:WIDTH];
                    wr_c       = |prod_reg[2*WIDTH-1:WIDTH];
                    state_next = S_DONE;
                end else begin
                    prod_next = {mul_sum, prod_reg[WIDTH-1:1]};
                    cnt_next  = cnt_reg + 1'b1;
                end
            end
            S_SHIFT: begin
                if (cnt_reg == CNT_W'(1)) begin
                    wr         = 1'b1;
                    wr_lo      = shifted;
                    wr_c       = sh_reg[0];
                    state_next = S_DONE;
                end else begin
                    sh_next  = shifted;
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase

        if (accept) begin
            case (FS)
                FS_MUL: begin
                    prod_next  = {{WIDTH{1'b0}}, B};
                    mcand_next = A;
                    cnt_next   = '0;
                    state_next = S_MUL;
                end
                FS_ADC: begin
                    wr         = 1'b1;
                    {wr_c, wr_lo} = adc_sum;
                    state_next = S_DONE;
                end
                FS_ASR: begin
                    if (idx == '0) begin
                        wr         = 1'b1;
                        wr_lo      = A;
                        state_next = S_DONE;
                    end else begin
                        sh_next    = A;
                        cnt_next   = CNT_W'(idx);
                        state_next = S_SHIFT;
                    end
                end
                FS_CLR: begin
                    wr         = 1'b1;
                    wr_lo      = A & ~bitmask;
                    state_next = S_DONE;
                end
                FS_SET: begin
                    wr         = 1'b1;
                    wr_lo      = A | bitmask;
                    state_next = S_DONE;
                end
                FS_TST: begin
                    wr         = 1'b1;
                    wr_lo      = A;
                    is_tst     = 1'b1;
                    wr_z       = ~A[idx];
                    state_next = S_DONE;
                end
                default: state_next = state_reg;
            endcase
        end

        if (wr) begin
            res_lo_next = wr_lo;
            res_hi_next = wr_hi;
            c_next      = wr_c;
            z_next      = is_tst ? wr_z : (wr_lo == '0);
            n_next      = wr_lo[WIDTH-1];
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_reg  <= S_IDLE;
            prod_reg   <= '0;
            mcand_reg  <= '0;
            sh_reg     <= '0;
            cnt_reg    <= '0;
            res_lo_reg <= '0;
            res_hi_reg <= '0;
            c_reg      <= 1'b0;
            z_reg      <= 1'b0;
            n_reg      <= 1'b0;
        end else begin
            state_reg  <= state_next;
            prod_reg   <= prod_next;
            mcand_reg  <= mcand_next;
            sh_reg     <= sh_next;
            cnt_reg    <= cnt_next;
            res_lo_reg <= res_lo_next;
            res_hi_reg <= res_hi_next;
            c_reg      <= c_next;
            z_reg      <= z_next;
            n_reg      <= n_next;
        end
    end

    assign Busy     = (state_reg == S_MUL) || (state_reg == S_SHIFT);
    assign Done     = (state_reg == S_DONE);
    assign Result   = res_lo_reg;
    assign ResultHi = res_hi_reg;
    assign C        = c_reg;
    assign Z        = z_reg;
    assign N        = n_reg;
endmodule

// File: tb/tb_sfu_sequencer.sv
// Directed testbench for sfu_sequencer: handshake timing, each operation, flags and reset abort.
module tb_sfu_sequencer;
    localparam int W = 16;

    logic         Clock, Resetn, Start, Cin;
    logic [4:0]   FS;
    logic [W-1:0] A, B;
    logic         SFU_sel, Busy, Done, C, Z, N;
    logic [W-1:0] Result, ResultHi;
    logic [34:0]  outv;

    int tests = 0;
    int fails = 0;
    int lat, busy, seen;

    sfu_sequencer #(.WIDTH(W)) dut (
        .Clock(Clock), .Resetn(Resetn), .Start(Start), .FS(FS), .A(A), .B(B), .Cin(Cin),
        .SFU_sel(SFU_sel), .Busy(Busy), .Done(Done), .Result(Result), .ResultHi(ResultHi),
        .C(C), .Z(Z), .N(N)
    );

    assign outv = {Result, ResultHi, C, Z, N};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] fs, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin);
        FS = fs; A = a; B = b; Cin = cin; Start = 1'b1;
    endtask

    // Accept edge is the posedge inside this task; returns 1 ns after it
    task automatic start_op(input logic [4:0] fs, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin);
        drive(fs, a, b, cin);
        @(posedge Clock); #1;
        Start = 1'b0; FS = 5'b00000;
    endtask

    task automatic wait_done(output int l, output int bz);
        l = 0; bz = 0;
        while (Done !== 1'b1 && l < 200) begin
            if (Busy === 1'b1) bz++;
            @(posedge Clock); #1;
            l++;
        end
    endtask

    initial begin
        Resetn = 1'b0; Start = 1'b0; FS = 5'b0; A = '0; B = '0; Cin = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        check("reset_state", {Busy, Done, outv}, 37'h0);
        @(negedge Clock) Resetn = 1'b1;
        @(posedge Clock); #1;

        // Decode boundaries
        FS = 5'b00101; #1; check("sel_00101", SFU_sel, 1'b0);
        FS = 5'b11001; #1; check("sel_11001", SFU_sel, 1'b0);
        FS = 5'b11010; #1; check("sel_11010", SFU_sel, 1'b1);
        FS = 5'b11111; #1; check("sel_11111", SFU_sel, 1'b1);

        // Non-SFU code with Start is ignored
        drive(5'b00101, 16'h1234, 16'h0010, 1'b0);
        @(posedge Clock); #1;
        check("nonsfu_idle", {Busy, Done}, 2'b00);
        @(posedge Clock); #1;
        Start = 1'b0;
        check("nonsfu_idle2", {Busy, Done}, 2'b00);

        // ADC with carry-out wrap
        start_op(5'b11011, 16'hFFFF, 16'h0001, 1'b1);
        check("adc_done", Done, 1'b1);
        check("adc_out", outv, {16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0});
        @(posedge Clock); #1;
        check("adc_idle_done", {Busy, Done}, 2'b00);
        check("adc_hold", outv, {16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0});

        start_op(5'b11011, 16'hFFFF, 16'h0000, 1'b1);
        check("adc_zero", {Done, outv}, {1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0});

        // MUL with an ADC request pulsed mid-operation
        start_op(5'b11010, 16'h1234, 16'h0010, 1'b0);
        check("mul_busy", {Busy, Done}, 2'b10);
        repeat (3) @(posedge Clock);
        #1;
        drive(5'b11011, 16'hFFFF, 16'hFFFF, 1'b1);
        @(posedge Clock); #1;
        Start = 1'b0; FS = 5'b00000;
        check("mul_ignore_busy", {Busy, Done}, 2'b10);
        wait_done(lat, busy);
        check("mul_latency", 4 + lat, W + 1);
        check("mul_out", outv, {16'h2340, 16'h0001, 1'b1, 1'b0, 1'b0});

        start_op(5'b11010, 16'hFFFF, 16'hFFFF, 1'b0);
        wait_done(lat, busy);
        check("mul_max_latency", lat, W + 1);
        check("mul_max_out", outv, {16'h0001, 16'hFFFE, 1'b1, 1'b0, 1'b0});

        // ASR
        start_op(5'b11100, 16'h8000, 16'h0003, 1'b0);
        wait_done(lat, busy);
        check("asr3_latency", lat, 3);
        check("asr3_busy", busy, 3);
        check("asr3_out", outv, {16'hF000, 16'h0000, 1'b0, 1'b0, 1'b1});

        start_op(5'b11100, 16'h8001, 16'h0001, 1'b0);
        wait_done(lat, busy);
        check("asr1_latency", lat, 1);
        check("asr1_out", outv, {16'hC000, 16'h0000, 1'b1, 1'b0, 1'b1});

        start_op(5'b11100, 16'h0005, 16'h0000, 1'b0);
        check("asr0_done", {Busy, Done}, 2'b01);
        check("asr0_out", outv, {16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0});

        // SET then CLR accepted back-to-back from DONE
        drive(5'b11110, 16'h0000, 16'h0005, 1'b0);
        @(posedge Clock); #1;
        check("set_out", {Done, outv}, {1'b1, 16'h0020, 16'h0000, 1'b0, 1'b0, 1'b0});
        drive(5'b11101, 16'hFFFF, 16'h000F, 1'b0);
        @(posedge Clock); #1;
        Start = 1'b0; FS = 5'b00000;
        check("clr_out", {Done, outv}, {1'b1, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 1'b0});
        @(posedge Clock); #1;
        check("clr_hold", {Done, outv}, {1'b0, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 1'b0});

        // TST
        start_op(5'b11111, 16'h0020, 16'h0004, 1'b0);
        check("tst_clear_bit", {Done, outv}, {1'b1, 16'h0020, 16'h0000, 1'b0, 1'b1, 1'b0});
        start_op(5'b11111, 16'h0020, 16'h0005, 1'b0);
        check("tst_set_bit", {Done, outv}, {1'b1, 16'h0020, 16'h0000, 1'b0, 1'b0, 1'b0});

        // Reset mid-MUL aborts asynchronously
        start_op(5'b11010, 16'h1234, 16'h0010, 1'b0);
        repeat (5) @(posedge Clock);
        #3;
        Resetn = 1'b0;
        #1;
        check("reset_async", {Busy, Done, outv}, 37'h0);
        @(posedge Clock);
        @(negedge Clock) Resetn = 1'b1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge Clock); #1;
            if (Done === 1'b1 || Busy === 1'b1) seen++;
        end
        check("reset_no_done", seen, 0);
        start_op(5'b11011, 16'h0001, 16'h0002, 1'b0);
        check("adc_after_reset", {Done, outv}, {1'b1, 16'h0003, 16'h0000, 1'b0, 1'b0, 1'b0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
